// File: rtl/sr_cmd_driver_if.sv
// Command handshake between a command source and sr_cmd_driver.
`timescale 1ns/1ps
interface sr_cmd_driver_if #(
  parameter int unsigned HOLD_W = 4
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (output cmd_valid, output cmd_op, output cmd_hold, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_hold, output cmd_ready);
endinterface

// File: rtl/sr_cmd_driver.sv
// Drives S/R pulses into an sr_flip_flop from a command stream, tracks the expected Q
// and checks the Q/Qbar feedback once each command has finished.
`timescale 1ns/1ps
module sr_cmd_driver #(
  parameter int unsigned HOLD_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_cmd_driver_if.slave   cmd,
  output logic             S,
  output logic             R,
  input  logic             q_fb,
  input  logic             qbar_fb,
  output logic             q_exp,
  output logic             q_known,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             err_clr,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int unsigned OP_W = 2;
  localparam logic [OP_W-1:0] OP_CLEAR  = 2'b01;
  localparam logic [OP_W-1:0] OP_SET    = 2'b10;
  localparam logic [OP_W-1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_CHECK} state_t;

  state_t             state, state_d;
  logic [HOLD_W-1:0]  cnt, cnt_d;
  logic               drv_s, drv_s_d, drv_r, drv_r_d;
  logic               s_d, r_d, q_exp_d, q_known_d, ready, ready_d, busy_d, err_d;
  logic [1:0]         err_code_d, new_bits;
  logic [CNT_W-1:0]   cmd_count_d;
  logic               op_set, op_clr;

  assign cmd.cmd_ready = ready;

  // Toggle resolves against the expected Q held before the accept edge.
  assign op_set = (cmd.cmd_op == OP_SET)   || ((cmd.cmd_op == OP_TOGGLE) && !q_exp);
  assign op_clr = (cmd.cmd_op == OP_CLEAR) || ((cmd.cmd_op == OP_TOGGLE) &&  q_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      drv_s     <= 1'b0;
      drv_r     <= 1'b0;
      S         <= 1'b0;
      R         <= 1'b0;
      q_exp     <= 1'b0;
      q_known   <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      cmd_count <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      drv_s     <= drv_s_d;
      drv_r     <= drv_r_d;
      S         <= s_d;
      R         <= r_d;
      q_exp     <= q_exp_d;
      q_known   <= q_known_d;
      ready     <= ready_d;
      busy      <= busy_d;
      err       <= err_d;
      err_code  <= err_code_d;
      cmd_count <= cmd_count_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    drv_s_d     = drv_s;
    drv_r_d     = drv_r;
    s_d         = S;
    r_d         = R;
    q_exp_d     = q_exp;
    q_known_d   = q_known;
    ready_d     = ready;
    cmd_count_d = cmd_count;
    new_bits    = 2'b00;

    case (state)
      ST_IDLE: begin
        s_d = 1'b0;
        r_d = 1'b0;
        if (cmd.cmd_valid && ready) begin
          // Counter holds remaining pulse cycles minus one; a zero hold means one cycle.
          cnt_d   = (cmd.cmd_hold == '0) ? '0 : cmd.cmd_hold - HOLD_W'(1);
          drv_s_d = op_set;
          drv_r_d = op_clr;
          s_d     = op_set;
          r_d     = op_clr;
          if (op_set) q_exp_d = 1'b1;
          if (op_clr) q_exp_d = 1'b0;
          ready_d = 1'b0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt == '0) begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt - HOLD_W'(1);
        end
      end
      ST_CHECK: begin
        s_d         = 1'b0;
        r_d         = 1'b0;
        new_bits[1] = (q_fb == qbar_fb);
        new_bits[0] = (q_known || drv_s || drv_r) && (q_fb != q_exp);
        if (drv_s || drv_r) q_known_d = 1'b1;
        cmd_count_d = cmd_count + CNT_W'(1);
        ready_d     = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // A fault seen on the clearing edge survives the clear.
    err_code_d = err_clr ? new_bits : (err_code | new_bits);
    err_d      = |err_code_d;
    busy_d     = !ready_d;
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Randomized bench for sr_cmd_driver against a command-level reference model
// and a behavioural flip-flop with injectable Q/Qbar faults.
`timescale 1ns/1ps
module tb_sr_cmd_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       S, R, q_fb, qbar_fb, q_exp, q_known, busy, err, err_clr;
  logic [1:0] err_code;
  logic [7:0] cmd_count;
  logic       ff_q;
  logic [1:0] fault;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit       m_qe, m_known, m_ff;
  bit [1:0] m_code;
  int       m_cnt;

  sr_cmd_driver_if #(.HOLD_W(4)) cif ();

  sr_cmd_driver #(.HOLD_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cif),
    .S         (S),
    .R         (R),
    .q_fb      (q_fb),
    .qbar_fb   (qbar_fb),
    .q_exp     (q_exp),
    .q_known   (q_known),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code),
    .err_clr   (err_clr),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;

  // Behavioural flip-flop plus fault injection (1: Q stuck 0, 2: Qbar equals Q).
  always @(posedge clk) begin
    if (S)      ff_q <= 1'b1;
    else if (R) ff_q <= 1'b0;
  end
  assign q_fb    = (fault == 2'd1) ? 1'b0 : ff_q;
  assign qbar_fb = (fault == 2'd1) ? 1'b1 : (fault == 2'd2) ? q_fb : ~ff_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) chk("s_and_r", 32'(S & R), 32'd0);

  task automatic model_reset();
    m_qe = 1'b0; m_known = 1'b0; m_code = 2'b00; m_cnt = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":q_exp"},     32'(q_exp),     32'(m_qe));
    chk({tag, ":q_known"},   32'(q_known),   32'(m_known));
    chk({tag, ":err_code"},  32'(err_code),  32'(m_code));
    chk({tag, ":err"},       32'(err),       32'(|m_code));
    chk({tag, ":cmd_count"}, 32'(cmd_count), 32'(m_cnt));
    chk({tag, ":ready"},     32'(cif.cmd_ready), 32'd1);
    chk({tag, ":busy"},      32'(busy),      32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cif.cmd_valid = 1'b0; err_clr = 1'b0; fault = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One command: waits for ready, runs it to completion and checks pulses and results.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] hold, input bit keep,
                        input logic [1:0] flt, input bit clr);
    int n, cyc, ns, nr;
    bit set_op, clr_op, known_after;
    bit qf, qb;
    bit [1:0] bits;
    cyc = 0;
    while (!cif.cmd_ready && cyc < 100) begin @(negedge clk); cyc++; end
    chk("ready_wait", 32'(cif.cmd_ready), 32'd1);
    fault = flt;
    cif.cmd_valid = 1'b1; cif.cmd_op = op; cif.cmd_hold = hold;
    n      = (hold == 4'd0) ? 1 : int'(hold);
    set_op = (op == 2'b10) || (op == 2'b11 && !m_qe);
    clr_op = (op == 2'b01) || (op == 2'b11 &&  m_qe);
    @(posedge clk);
    @(negedge clk);
    if (!keep) cif.cmd_valid = 1'b0;
    cif.cmd_op = 2'($urandom); cif.cmd_hold = 4'($urandom);
    cyc = 0; ns = 0; nr = 0;
    while (!cif.cmd_ready && cyc < 64) begin
      err_clr = (cyc == n) ? clr : 1'b0;
      if (S) ns++;
      if (R) nr++;
      cyc++;
      @(negedge clk);
    end
    err_clr = 1'b0;
    fault   = 2'd0;
    // Reference: flip-flop follows the pulse; checks happen once the pulse is over.
    if (set_op) begin m_qe = 1'b1; m_ff = 1'b1; end
    if (clr_op) begin m_qe = 1'b0; m_ff = 1'b0; end
    qf = (flt == 2'd1) ? 1'b0 : m_ff;
    qb = (flt == 2'd1) ? 1'b1 : (flt == 2'd2) ? qf : !m_ff;
    known_after = m_known || set_op || clr_op;
    bits[1] = (qf == qb);
    bits[0] = known_after && (qf != m_qe);
    m_code  = clr ? bits : (m_code | bits);
    m_known = known_after;
    m_cnt   = (m_cnt + 1) % 256;
    chk("busy_cycles", 32'(cyc), 32'(n + 1));
    chk("s_pulse",     32'(ns),  set_op ? 32'(n) : 32'd0);
    chk("r_pulse",     32'(nr),  clr_op ? 32'(n) : 32'd0);
    check_state("cmd");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; err_clr = 1'b0; fault = 2'd0;
    cif.cmd_valid = 1'b0; cif.cmd_op = 2'b00; cif.cmd_hold = 4'd0;
    model_reset();
    m_ff = 1'b0;
    @(negedge clk);
    chk("rst:S", 32'(S), 32'd0);
    chk("rst:R", 32'(R), 32'd0);
    check_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset in the middle of a 5-cycle set pulse
    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_op = 2'b10; cif.cmd_hold = 4'd5;
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("t1:S_cyc1", 32'(S), 32'd1);
    @(negedge clk);
    chk("t1:S_cyc2", 32'(S), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t1:S_async", 32'(S), 32'd0);
    chk("t1:R_async", 32'(R), 32'd0);
    chk("t1:ready_async", 32'(cif.cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    m_ff = 1'b1;
    check_state("t1");

    // Clear N=1 then set N=3, valid held high across both
    do_reset();
    do_cmd(2'b01, 4'd1, 1'b1, 2'd0, 1'b0);
    do_cmd(2'b10, 4'd3, 1'b0, 2'd0, 1'b0);
    chk("t2:count", 32'(cmd_count), 32'd2);

    // Unknown Q: hold then toggle must not flag a mismatch
    do_reset();
    do_cmd(2'b00, 4'd2, 1'b0, 2'd0, 1'b0);
    do_cmd(2'b11, 4'd4, 1'b0, 2'd0, 1'b0);
    chk("t3:q_known", 32'(q_known), 32'd1);

    // Q stuck low on a set, clear, then Qbar==Q with clear on the same edge
    do_cmd(2'b10, 4'd2, 1'b0, 2'd1, 1'b0);
    chk("t4:err_code", 32'(err_code), 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_code = 2'b00;
    chk("t4:err_cleared", 32'(err), 32'd0);
    do_cmd(2'b10, 4'd1, 1'b0, 2'd1, 1'b0);
    do_cmd(2'b00, 4'd1, 1'b0, 2'd2, 1'b1);
    chk("t4:same_edge", 32'(err_code), 32'd2);

    // Zero hold gives a one-cycle pulse; 256 commands wrap the counter
    do_reset();
    do_cmd(2'b01, 4'd0, 1'b0, 2'd0, 1'b0);
    do_reset();
    for (int i = 0; i < 256; i++)
      do_cmd(2'b00, 4'($urandom_range(0, 1)), 1'($urandom), 2'd0, 1'b0);
    chk("t5:wrap", 32'(cmd_count), 32'd0);

    // Random command mix with occasional faults and clears
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 5));
      do_cmd(2'($urandom), 4'($urandom), 1'($urandom), (r > 3) ? 2'(r - 3) : 2'd0,
             ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
